filter_out_fifo: RTL and testbench

FILTER_OUT_FIFO -- requirements
Module: filter_out_fifo

---
 rtl/filter_out_fifo.sv | 159 +++++++++++++++
 tb/tb_filter_out_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/filter_out_fifo.sv
// -----------------------------------------------------------------------------
// filter_out_fifo
//   Output buffer for a sample-rate filter. Samples strobed by ce_in are
//   queued and handed to a consumer with a valid/ready handshake. When the
//   buffer is full and nothing is read, incoming samples are dropped and
//   counted. m_data is a register loaded with a registered read from the
//   storage array, with a bypass of data_in when the queue is (or becomes)
//   empty.
//
//   Optional feature: define FILTER_OUT_FIFO_PEAK_EN to track the largest
//   |sample| accepted since the last clear_ovf. Without it peak_abs is 0.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   ce_in      sample strobe, qualifies data_in
//   data_in    signed sfix11_En3 sample
//   m_ready    consumer accepts m_data this cycle
//   clear_ovf  clears overflow, ovf_count and peak_abs (clear-then-update)
//   m_valid    m_data holds an unread sample
//   m_data     oldest stored sample, bit-exact copy of data_in
//   level      occupancy 0..DEPTH
//   overflow   sticky: at least one sample dropped
//   ovf_count  dropped-sample count, saturating at 255
//   peak_abs   unsigned max |sample| written since clear (0 if feature off)
// -----------------------------------------------------------------------------
module filter_out_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ce_in,
   input  logic [10:0]                data_in,
   input  logic                       m_ready,
   input  logic                       clear_ovf,
   output logic                       m_valid,
   output logic [10:0]                m_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [7:0]                 ovf_count,
   output logic [10:0]                peak_abs
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [10:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [LW-1:0] level_reg;
   logic [10:0]   m_data_reg;
   logic          overflow_reg;
   logic [7:0]    ovf_count_reg;

   logic          pop;
   logic          push;
   logic          drop;
   logic          full;
   logic          empty;
   logic [AW-1:0] rd_ptr_inc;

   always_comb begin
      empty      = (level_reg == '0);
      full       = (level_reg == LW'(DEPTH));
      pop        = !empty && m_ready;
      // A read in the same cycle frees a slot, so a full FIFO still accepts.
      push       = ce_in && (!full || pop);
      drop       = ce_in && full && !pop;
      rd_ptr_inc = rd_ptr_reg + AW'(1);
   end

   // Storage: no reset, contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= data_in;
   end

   // Head register. On a pop with more than one entry left, the next head is
   // already in the array and never collides with the write address. When the
   // queue is empty, or drains to empty while a new sample arrives, data_in is
   // bypassed straight into the head.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_data_reg <= '0;
      end else if (pop && level_reg != LW'(1)) begin
         m_data_reg <= mem[rd_ptr_inc];
      end else if (push && (empty || (pop && level_reg == LW'(1)))) begin
         m_data_reg <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (pop)
            rd_ptr_reg <= rd_ptr_inc;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         unique case ({push, pop})
            2'b10:   level_reg <= level_reg + LW'(1);
            2'b01:   level_reg <= level_reg - LW'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   // Drop accounting: clear first, then apply this cycle's drop.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_reg  <= 1'b0;
         ovf_count_reg <= '0;
      end else if (clear_ovf) begin
         overflow_reg  <= drop;
         ovf_count_reg <= {7'd0, drop};
      end else if (drop) begin
         overflow_reg <= 1'b1;
         if (ovf_count_reg != 8'hFF)
            ovf_count_reg <= ovf_count_reg + 8'd1;
      end
   end

`ifdef FILTER_OUT_FIFO_PEAK_EN
   logic [10:0] abs_in;
   logic [10:0] peak_reg;

   // |-1024| does not fit the 1023 ceiling of the magnitude, so it saturates.
   always_comb begin
      abs_in = data_in;
      if (data_in == 11'h400)
         abs_in = 11'd1023;
      else if (data_in[10])
         abs_in = ~data_in + 11'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         peak_reg <= '0;
      end else if (clear_ovf) begin
         peak_reg <= push ? abs_in : 11'd0;
      end else if (push && abs_in > peak_reg) begin
         peak_reg <= abs_in;
      end
   end

   assign peak_abs = peak_reg;
`else
   assign peak_abs = '0;
`endif

   assign m_valid   = !empty;
   assign m_data    = m_data_reg;
   assign level     = level_reg;
   assign overflow  = overflow_reg;
   assign ovf_count = ovf_count_reg;

endmodule

// File: tb/tb_filter_out_fifo.sv
// -----------------------------------------------------------------------------
// tb_filter_out_fifo
//   Directed scenarios plus randomized traffic for filter_out_fifo, checked
//   against a queue-based reference model after every clock edge.
// -----------------------------------------------------------------------------
module tb_filter_out_fifo;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ce_in = 1'b0;
   logic [10:0]   data_in = '0;
   logic          m_ready = 1'b0;
   logic          clear_ovf = 1'b0;
   logic          m_valid;
   logic [10:0]   m_data;
   logic [LW-1:0] level;
   logic          overflow;
   logic [7:0]    ovf_count;
   logic [10:0]   peak_abs;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int mq[$];          // queued samples as signed integers, head at [0]
   int m_ovf   = 0;
   int m_cnt   = 0;
   int m_peak  = 0;
   int m_mdata = 0;    // only meaningful right after reset

   filter_out_fifo #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .ce_in     (ce_in),
      .data_in   (data_in),
      .m_ready   (m_ready),
      .clear_ovf (clear_ovf),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .level     (level),
      .overflow  (overflow),
      .ovf_count (ovf_count),
      .peak_abs  (peak_abs)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int sx11(input logic [10:0] v);
      return int'($signed(v));
   endfunction

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic step(input bit rst, input bit ce, input int d, input bit rdy, input bit clr);
      bit pop, push, drop;
      int a;
      reset     = rst;
      ce_in     = ce;
      data_in   = 11'(d);
      m_ready   = rdy;
      clear_ovf = clr;
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_cnt = 0; m_peak = 0; m_mdata = 0;
      end else begin
         pop  = (mq.size() > 0) && rdy;
         push = ce && (mq.size() < DEPTH || pop);
         drop = ce && !push;
         a    = (d < 0) ? -d : d;
         if (a > 1023) a = 1023;
         if (clr) begin
            m_ovf = drop ? 1 : 0;
            m_cnt = drop ? 1 : 0;
`ifdef FILTER_OUT_FIFO_PEAK_EN
            m_peak = push ? a : 0;
`endif
         end else begin
            if (drop) begin
               m_ovf = 1;
               if (m_cnt < 255) m_cnt++;
            end
`ifdef FILTER_OUT_FIFO_PEAK_EN
            if (push && a > m_peak) m_peak = a;
`endif
         end
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(d);
      end
      @(posedge clk);
      #1;
      check("m_valid", int'(m_valid), (mq.size() > 0) ? 1 : 0);
      check("level", int'(level), mq.size());
      if (mq.size() > 0)
         check("m_data", sx11(m_data), mq[0]);
      else if (rst)
         check("m_data_rst", int'(m_data), m_mdata);
      check("overflow", int'(overflow), m_ovf);
      check("ovf_count", int'(ovf_count), m_cnt);
      check("peak_abs", int'(peak_abs), m_peak);
      $display("cyc rst=%0b ce=%0b d=%0d rdy=%0b clr=%0b -> valid=%0b data=%0d lvl=%0d ovf=%0b cnt=%0d peak=%0d",
               rst, ce, d, rdy, clr, m_valid, sx11(m_data), level, overflow, ovf_count, peak_abs);
   endtask

   initial begin
      #2;
      // Reset state
      step(1, 0, 0, 0, 0);
      step(1, 1, 7, 1, 1);

      // Single write, held by m_ready=0
      step(0, 1, 5, 0, 0);
      check("single_valid", int'(m_valid), 1);
      check("single_data", sx11(m_data), 5);
      check("single_level", int'(level), 1);
      step(0, 0, 0, 0, 0);   // stays stable while not ready

      // Fill 1..8 then drop 9
      step(1, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) step(0, 1, i, 0, 0);
      step(0, 1, 9, 0, 0);
      check("full_level", int'(level), 8);
      check("full_ovf", int'(overflow), 1);
      check("full_cnt", int'(ovf_count), 1);
      check("full_head", sx11(m_data), 1);

      // Full with simultaneous write and read
      step(0, 0, 0, 0, 1);
      step(0, 1, 9, 1, 0);
      check("fullrw_level", int'(level), 8);
      check("fullrw_ovf", int'(overflow), 0);
      check("fullrw_head", sx11(m_data), 2);

      // Saturating drop counter, then clear
      for (int i = 0; i < 300; i++) step(0, 1, 100 + i, 0, 0);
      check("sat_cnt", int'(ovf_count), 255);
      step(0, 0, 0, 0, 1);
      check("clr_ovf", int'(overflow), 0);
      check("clr_cnt", int'(ovf_count), 0);
      // Clear coinciding with a drop
      step(0, 1, 11, 0, 1);
      check("clrdrop_cnt", int'(ovf_count), 1);

      // Empty FIFO with ce_in and m_ready: write only
      step(1, 0, 0, 0, 0);
      step(0, 1, -3, 1, 0);
      check("empty_rw_level", int'(level), 1);

      // Peak tracking
      step(1, 0, 0, 0, 0);
      step(0, 1, 3, 0, 0);
      step(0, 1, -1024, 0, 0);
      step(0, 1, 700, 0, 0);
`ifdef FILTER_OUT_FIFO_PEAK_EN
      check("peak_sat", int'(peak_abs), 1023);
`else
      check("peak_off", int'(peak_abs), 0);
`endif

      // Reset with level=5
      step(0, 1, 1, 0, 0);
      step(0, 1, 2, 0, 0);
      check("pre_rst_level", int'(level), 5);
      step(1, 1, 9, 1, 1);
      check("rst5_level", int'(level), 0);
      check("rst5_valid", int'(m_valid), 0);
      check("rst5_data", int'(m_data), 0);

      // Randomized traffic with phases biasing toward full and toward empty
      for (int i = 0; i < 3000; i++) begin
         int phase;
         bit ce, rdy, clr, rst;
         phase = (i / 200) % 3;
         ce  = ($urandom_range(99) < (phase == 1 ? 90 : (phase == 2 ? 30 : 60)));
         rdy = ($urandom_range(99) < (phase == 1 ? 20 : (phase == 2 ? 90 : 55)));
         clr = ($urandom_range(99) < 3);
         rst = ($urandom_range(999) < 3);
         step(rst, ce, int'($urandom_range(2047)) - 1024, rdy, clr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
